// File: rtl/reg_writeback_if.sv
// reg_writeback_if: result handshakes from ALU/load paths plus register file write port and status.
interface reg_writeback_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int LW = 3
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          write_en;
    logic [AW-1:0] write_a;
    logic [DW-1:0] write_data;
    logic [31:0]   pending;
    logic [LW-1:0] level;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, write_en, write_a, write_data, pending, level
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, write_en, write_a, write_data, pending, level
    );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: in-order write-back queue feeding the register file write port,
// with ALU-priority enqueue arbitration and an in-flight register bitmap.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input logic            clk,
    input logic            rst,
    reg_writeback_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LW-1:0]    level;
    logic             space;
    logic             acc_alu;
    logic             acc_mem;
    logic             push;
    logic             pop;
    logic [AW-1:0]    in_addr;
    logic [DW-1:0]    in_data;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [31:0]      pend;

    // Space is judged on registered level only; a same-cycle pop never frees room.
    assign space         = !rst && (level < LW'(DEPTH));
    assign bus.alu_ready = space;
    assign bus.mem_ready = space && !bus.alu_valid;
    assign acc_alu       = bus.alu_valid && space;
    assign acc_mem       = bus.mem_valid && space && !bus.alu_valid;
    assign in_addr       = acc_alu ? bus.alu_addr : bus.mem_addr;
    assign in_data       = acc_alu ? bus.alu_data : bus.mem_data;
    assign push          = (acc_alu || acc_mem) && (in_addr != '0);
    assign pop           = level != '0;

    assign bus.level      = level;
    assign bus.write_en   = we;
    assign bus.write_a    = wa;
    assign bus.write_data = wd;
    assign bus.pending    = pend;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= in_addr;
            q_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
            vld   <= '0;
            we    <= 1'b0;
            wa    <= '0;
            wd    <= '0;
        end else begin
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
                wa        <= q_addr[head];
                wd        <= q_data[head];
            end
            we    <= pop;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend[q_addr[i]] = 1'b1;
        if (we) pend[wa] = 1'b1;
        pend[0] = 1'b0;
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus with a scoreboard queue of accepted writes,
// compared against the register file write port and status outputs every cycle.
module tb_reg_writeback;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr  = 0;
    int   n_ret = 0;
    ent_t sb[$];
    logic m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic acc_last = 1'b0;
    logic armed = 1'b0;

    reg_writeback_if #(.DW(32), .AW(5), .LW(3)) bus ();

    reg_writeback #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference queue: pop head into the write register, then append this edge's acceptance.
    always @(posedge clk) begin
        ent_t e;
        logic rdy;
        logic accm;
        if (rst) begin
            sb.delete();
            m_we = 1'b0;
            m_wa = '0;
            m_wd = '0;
            acc_last = 1'b0;
            armed = 1'b1;
        end else begin
            rdy = sb.size() < 4;
            acc_last = bus.alu_valid && rdy;
            accm = bus.mem_valid && rdy && !bus.alu_valid;
            m_we = sb.size() > 0;
            if (m_we) begin
                e = sb.pop_front();
                m_wa = e.a;
                m_wd = e.d;
                n_ret++;
            end
            if (acc_last && bus.alu_addr != 0) sb.push_back('{bus.alu_addr, bus.alu_data});
            else if (accm && bus.mem_addr != 0) sb.push_back('{bus.mem_addr, bus.mem_data});
        end
    end

    always @(negedge clk) begin
        logic [31:0] ep;
        if (armed) begin
            ep = '0;
            foreach (sb[i]) ep[sb[i].a] = 1'b1;
            if (m_we) ep[m_wa] = 1'b1;
            ep[0] = 1'b0;
            chk("alu_ready", bus.alu_ready, !rst && sb.size() < 4);
            chk("mem_ready", bus.mem_ready, !rst && sb.size() < 4 && !bus.alu_valid);
            chk("write_en", bus.write_en, m_we);
            chk("write_a", bus.write_a, m_wa);
            chk("write_data", bus.write_data, m_wd);
            chk("level", bus.level, sb.size());
            chk("pending", bus.pending, ep);
            if (bus.write_en === 1'b1) n_wr++;
        end
    end

    initial begin
        int got;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        // single ALU write
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        cyc();
        bus.alu_valid = 1'b0;
        chk("t1_pend_acc", bus.pending[5], 1'b1);
        chk("t1_we_acc", bus.write_en, 1'b0);
        cyc();
        chk("t1_we", bus.write_en, 1'b1);
        chk("t1_a", bus.write_a, 5'd5);
        chk("t1_d", bus.write_data, 32'hDEADBEEF);
        chk("t1_pend_wr", bus.pending[5], 1'b1);
        cyc();
        chk("t1_we_off", bus.write_en, 1'b0);
        chk("t1_pend_off", bus.pending, 32'h0);
        cyc();
        // both sources offering; load waits behind ALU
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'd9;
        bus.mem_data  = 32'h9999_0009;
        for (int i = 1; i <= 8; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = 5'(i);
            bus.alu_data  = 32'h1000_0000 + i;
            cyc();
        end
        bus.alu_valid = 1'b0;
        cyc();
        bus.mem_valid = 1'b0;
        repeat (4) cyc();
        // continuous ALU offers with random gaps
        got = 0;
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'($urandom_range(1, 31));
        bus.alu_data  = $urandom;
        for (int k = 0; k < 200 && got < 20; k++) begin
            cyc();
            if (acc_last) begin
                got++;
                bus.alu_addr = 5'($urandom_range(1, 31));
                bus.alu_data = $urandom;
            end
            bus.alu_valid = $urandom_range(0, 3) != 0;
        end
        bus.alu_valid = 1'b0;
        repeat (4) cyc();
        // r0 is swallowed
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd0;
        bus.alu_data  = 32'h12345678;
        cyc();
        bus.alu_valid = 1'b0;
        chk("r0_level", bus.level, 3'd0);
        cyc();
        chk("r0_we", bus.write_en, 1'b0);
        chk("r0_pend", bus.pending, 32'h0);
        // same-register ordering
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd3;
        bus.alu_data  = 32'h1;
        cyc();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 5'd3;
        bus.mem_data  = 32'h2;
        cyc();
        bus.mem_valid = 1'b0;
        chk("r3_first", bus.write_data, 32'h1);
        cyc();
        chk("r3_second", bus.write_data, 32'h2);
        chk("r3_pend_hold", bus.pending[3], 1'b1);
        cyc();
        chk("r3_pend_drop", bus.pending[3], 1'b0);
        // reset mid-burst
        for (int i = 10; i <= 12; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = 5'(i);
            bus.alu_data  = 32'hA000_0000 + i;
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.alu_valid = 1'b0;
        chk("rst_we", bus.write_en, 1'b0);
        chk("rst_level", bus.level, 3'd0);
        chk("rst_pend", bus.pending, 32'h0);
        chk("rst_a", bus.write_a, 5'd0);
        chk("rst_d", bus.write_data, 32'h0);
        repeat (3) cyc();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd7;
        bus.alu_data  = 32'h7777_0007;
        cyc();
        bus.alu_valid = 1'b0;
        cyc();
        chk("r7_we", bus.write_en, 1'b1);
        chk("r7_a", bus.write_a, 5'd7);
        chk("r7_d", bus.write_data, 32'h7777_0007);
        repeat (5) cyc();
        chk("write_count", n_wr, n_ret);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
